decode_format_mux: RTL and testbench

// - Successor to the fixed 6-way decode-stage-2 mux: merges NUM_FMT parallel format-decoder outputs onto one bus.
// - Adds fixed-priority arbitration with collision flag, immediate extend/shift, a DEPTH-entry output FIFO and valid/ready handshake.
// - Sits between the parallel format decoders and the issue/register-read stage.

---
 rtl/decode_format_mux_if.sv | 59 +++++
 rtl/decode_format_mux.sv | 149 ++++++++++++++
 tb/tb_decode_format_mux.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_format_mux_if.sv
// Handshake/bus bundle between the format decoders, decode_format_mux and the issue stage.
// Optional perf outputs exist only when DECODE_MUX_PERF_EN is defined.
interface decode_format_mux_if #(
    parameter int NUM_FMT = 6,
    parameter int IMM_W   = 16,
    parameter int CTRL_W  = 40,
    parameter int ADDR_W  = 64,
    parameter int OPC_W   = 6,
    parameter int IDX_W   = 3
);
    logic                        flush_i;
    logic [ADDR_W-1:0]           instructionAddress_i;
    logic [OPC_W-1:0]            opcode_i;
    logic [NUM_FMT-1:0]          fmtValid_i;
    logic [NUM_FMT*IMM_W-1:0]    fmtImm_i;
    logic [NUM_FMT*6-1:0]        fmtImmShift_i;
    logic [NUM_FMT-1:0]          fmtImmSigned_i;
    logic [NUM_FMT*CTRL_W-1:0]   fmtCtrl_i;
    logic                        ready_o;
    logic                        valid_o;
    logic                        ready_i;
    logic [ADDR_W-1:0]           instructionAddress_o;
    logic [OPC_W-1:0]            opcode_o;
    logic [63:0]                 imm_o;
    logic [CTRL_W-1:0]           ctrl_o;
    logic [IDX_W-1:0]            formatIndex_o;
    logic                        multiHit_o;
`ifdef DECODE_MUX_PERF_EN
    logic [31:0]                 perfIssued_o;
    logic [31:0]                 perfCollide_o;
    logic [31:0]                 perfStall_o;

    modport slave (
        input  flush_i, instructionAddress_i, opcode_i, fmtValid_i, fmtImm_i,
               fmtImmShift_i, fmtImmSigned_i, fmtCtrl_i, ready_i,
        output ready_o, valid_o, instructionAddress_o, opcode_o, imm_o, ctrl_o,
               formatIndex_o, multiHit_o, perfIssued_o, perfCollide_o, perfStall_o
    );
    modport master (
        output flush_i, instructionAddress_i, opcode_i, fmtValid_i, fmtImm_i,
               fmtImmShift_i, fmtImmSigned_i, fmtCtrl_i, ready_i,
        input  ready_o, valid_o, instructionAddress_o, opcode_o, imm_o, ctrl_o,
               formatIndex_o, multiHit_o, perfIssued_o, perfCollide_o, perfStall_o
    );
`else
    modport slave (
        input  flush_i, instructionAddress_i, opcode_i, fmtValid_i, fmtImm_i,
               fmtImmShift_i, fmtImmSigned_i, fmtCtrl_i, ready_i,
        output ready_o, valid_o, instructionAddress_o, opcode_o, imm_o, ctrl_o,
               formatIndex_o, multiHit_o
    );
    modport master (
        output flush_i, instructionAddress_i, opcode_i, fmtValid_i, fmtImm_i,
               fmtImmShift_i, fmtImmSigned_i, fmtCtrl_i, ready_i,
        input  ready_o, valid_o, instructionAddress_o, opcode_o, imm_o, ctrl_o,
               formatIndex_o, multiHit_o
    );
`endif
endinterface

// File: rtl/decode_format_mux.sv
// Fixed-priority merge of parallel format-decoder outputs into a small output FIFO.
// Define DECODE_MUX_PERF_EN to add saturating issue/collision/stall counters.
module decode_format_mux #(
    parameter int NUM_FMT = 6,
    parameter int IMM_W   = 16,
    parameter int CTRL_W  = 40,
    parameter int ADDR_W  = 64,
    parameter int OPC_W   = 6,
    parameter int DEPTH   = 2,
    parameter int IDX_W   = 3
) (
    input  logic           clock_i,
    input  logic           reset_i,
    decode_format_mux_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W-1:0]  win_idx;
    logic [IMM_W-1:0]  win_imm;
    logic [5:0]        win_shift;
    logic              win_signed;
    logic [CTRL_W-1:0] win_ctrl;
    logic              any_hit;
    logic              multi_hit;
    logic [63:0]       imm_ext;
    logic [63:0]       imm_final;

    logic [ADDR_W-1:0] addr_q  [DEPTH];
    logic [OPC_W-1:0]  opc_q   [DEPTH];
    logic [63:0]       imm_q   [DEPTH];
    logic [CTRL_W-1:0] ctrl_q  [DEPTH];
    logic [IDX_W-1:0]  idx_q   [DEPTH];
    logic              multi_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;

    // Scanning from the top down leaves the lowest set channel as the winner.
    always_comb begin
        win_idx    = '0;
        win_imm    = '0;
        win_shift  = '0;
        win_signed = 1'b0;
        win_ctrl   = '0;
        for (int k = NUM_FMT - 1; k >= 0; k--) begin
            if (bus.fmtValid_i[k]) begin
                win_idx    = IDX_W'(k);
                win_imm    = bus.fmtImm_i[k*IMM_W +: IMM_W];
                win_shift  = bus.fmtImmShift_i[k*6 +: 6];
                win_signed = bus.fmtImmSigned_i[k];
                win_ctrl   = bus.fmtCtrl_i[k*CTRL_W +: CTRL_W];
            end
        end
    end

    assign any_hit   = |bus.fmtValid_i;
    assign multi_hit = |(bus.fmtValid_i & (bus.fmtValid_i - NUM_FMT'(1)));

    assign imm_ext   = win_signed ? {{(64-IMM_W){win_imm[IMM_W-1]}}, win_imm}
                                  : {{(64-IMM_W){1'b0}}, win_imm};
    assign imm_final = imm_ext << win_shift;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign push  = any_hit && !full && !bus.flush_i;
    assign pop   = !empty && bus.ready_i && !bus.flush_i;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i]  <= '0;
                opc_q[i]   <= '0;
                imm_q[i]   <= '0;
                ctrl_q[i]  <= '0;
                idx_q[i]   <= '0;
                multi_q[i] <= 1'b0;
            end
        end else if (bus.flush_i) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                addr_q[wr_ptr]  <= bus.instructionAddress_i;
                opc_q[wr_ptr]   <= bus.opcode_i;
                imm_q[wr_ptr]   <= imm_final;
                ctrl_q[wr_ptr]  <= win_ctrl;
                idx_q[wr_ptr]   <= win_idx;
                multi_q[wr_ptr] <= multi_hit;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign bus.ready_o              = !full;
    assign bus.valid_o              = !empty;
    assign bus.instructionAddress_o = addr_q[rd_ptr];
    assign bus.opcode_o             = opc_q[rd_ptr];
    assign bus.imm_o                = imm_q[rd_ptr];
    assign bus.ctrl_o               = ctrl_q[rd_ptr];
    assign bus.formatIndex_o        = idx_q[rd_ptr];
    assign bus.multiHit_o           = multi_q[rd_ptr];

`ifdef DECODE_MUX_PERF_EN
    logic [31:0] perf_issued;
    logic [31:0] perf_collide;
    logic [31:0] perf_stall;

    // Counters survive flush so software sees whole-run totals.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            perf_issued  <= '0;
            perf_collide <= '0;
            perf_stall   <= '0;
        end else begin
            if (pop && perf_issued != 32'hFFFF_FFFF) begin
                perf_issued <= perf_issued + 32'd1;
            end
            if (push && multi_hit && perf_collide != 32'hFFFF_FFFF) begin
                perf_collide <= perf_collide + 32'd1;
            end
            if (any_hit && full && perf_stall != 32'hFFFF_FFFF) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end

    assign bus.perfIssued_o  = perf_issued;
    assign bus.perfCollide_o = perf_collide;
    assign bus.perfStall_o   = perf_stall;
`endif
endmodule

// File: tb/tb_decode_format_mux.sv
// Self-checking bench for decode_format_mux: directed scenarios plus a random run
// against a queue-based reference model.
module tb_decode_format_mux;
    localparam int NUM_FMT = 6;
    localparam int IMM_W   = 16;
    localparam int CTRL_W  = 40;
    localparam int ADDR_W  = 64;
    localparam int OPC_W   = 6;
    localparam int DEPTH   = 2;
    localparam int IDX_W   = 3;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [OPC_W-1:0]  opc;
        logic [63:0]       imm;
        logic [CTRL_W-1:0] ctrl;
        logic [IDX_W-1:0]  idx;
        logic              multi;
    } entry_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    entry_t model_q[$];

    decode_format_mux_if #(.NUM_FMT(NUM_FMT), .IMM_W(IMM_W), .CTRL_W(CTRL_W),
                           .ADDR_W(ADDR_W), .OPC_W(OPC_W), .IDX_W(IDX_W)) bus ();

    decode_format_mux #(.NUM_FMT(NUM_FMT), .IMM_W(IMM_W), .CTRL_W(CTRL_W), .ADDR_W(ADDR_W),
                        .OPC_W(OPC_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clock_i(clk),
        .reset_i(rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_imm(logic [15:0] raw, logic sgn, logic [5:0] sh);
        longint v;
        v = sgn ? longint'($signed(raw)) : longint'({48'd0, raw});
        return 64'(v) << sh;
    endfunction

    task automatic clear_inputs();
        bus.flush_i              = 1'b0;
        bus.fmtValid_i           = '0;
        bus.fmtImm_i             = '0;
        bus.fmtImmShift_i        = '0;
        bus.fmtImmSigned_i       = '0;
        bus.fmtCtrl_i            = '0;
        bus.instructionAddress_i = '0;
        bus.opcode_i             = '0;
    endtask

    task automatic set_ch(int k, logic [15:0] imm, logic [5:0] sh, logic sgn, logic [39:0] ctrl);
        bus.fmtValid_i[k]                  = 1'b1;
        bus.fmtImm_i[k*IMM_W +: IMM_W]     = imm;
        bus.fmtImmShift_i[k*6 +: 6]        = sh;
        bus.fmtImmSigned_i[k]              = sgn;
        bus.fmtCtrl_i[k*CTRL_W +: CTRL_W]  = ctrl;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.ready_i = 1'b0;
        do_reset();
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.valid_o); end
        checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.ready_o); end
        checks++; if (bus.imm_o !== 64'd0) begin errors++; $display("FAIL reset_imm: got %h want 0", bus.imm_o); end
        checks++; if (bus.ctrl_o !== '0 || bus.formatIndex_o !== '0 || bus.multiHit_o !== 1'b0) begin
            errors++; $display("FAIL reset_data: ctrl=%h idx=%0d multi=%b want all 0", bus.ctrl_o, bus.formatIndex_o, bus.multiHit_o);
        end
    endtask

    task automatic test_single_hit();
        clear_inputs();
        bus.ready_i = 1'b1;
        bus.instructionAddress_i = 64'h0000_1234_5678_9ABC;
        bus.opcode_i = 6'h2A;
        set_ch(3, 16'h8000, 6'd16, 1'b1, 40'hAA_BBCC_DDEE);
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL single_no_bypass: got %b want 0", bus.valid_o); end
        tick();
        clear_inputs();
        checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", bus.valid_o); end
        checks++; if (bus.imm_o !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("FAIL single_imm: got %h want ffffffff80000000", bus.imm_o); end
        checks++; if (bus.formatIndex_o !== 3'd3 || bus.multiHit_o !== 1'b0) begin
            errors++; $display("FAIL single_idx: idx=%0d multi=%b want 3/0", bus.formatIndex_o, bus.multiHit_o);
        end
        checks++; if (bus.instructionAddress_o !== 64'h0000_1234_5678_9ABC || bus.opcode_o !== 6'h2A || bus.ctrl_o !== 40'hAA_BBCC_DDEE) begin
            errors++; $display("FAIL single_fields: addr=%h opc=%h ctrl=%h", bus.instructionAddress_o, bus.opcode_o, bus.ctrl_o);
        end
        tick();
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL single_pop: got %b want 0", bus.valid_o); end
    endtask

    task automatic test_collision();
        clear_inputs();
        bus.ready_i = 1'b0;
        set_ch(1, 16'h0123, 6'd0, 1'b0, 40'h11_1111_1111);
        set_ch(4, 16'h7777, 6'd8, 1'b1, 40'h44_4444_4444);
        tick();
        clear_inputs();
        checks++; if (bus.formatIndex_o !== 3'd1 || bus.multiHit_o !== 1'b1) begin
            errors++; $display("FAIL collide_idx: idx=%0d multi=%b want 1/1", bus.formatIndex_o, bus.multiHit_o);
        end
        checks++; if (bus.imm_o !== 64'h123 || bus.ctrl_o !== 40'h11_1111_1111) begin
            errors++; $display("FAIL collide_fields: imm=%h ctrl=%h want 123/1111111111", bus.imm_o, bus.ctrl_o);
        end
        bus.ready_i = 1'b1;
        tick();
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL collide_loser_dropped: valid=%b want 0", bus.valid_o); end
    endtask

    task automatic test_backpressure();
        clear_inputs();
        bus.ready_i = 1'b0;
        set_ch(2, 16'h00A1, 6'd0, 1'b0, 40'hA1);
        tick();
        clear_inputs();
        set_ch(5, 16'h00B2, 6'd0, 1'b0, 40'hB2);
        tick();
        clear_inputs();
        checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b want 0", bus.ready_o); end
        set_ch(0, 16'h00C3, 6'd0, 1'b0, 40'hC3);
        tick();
        clear_inputs();
        checks++; if (bus.valid_o !== 1'b1 || bus.imm_o !== 64'hA1 || bus.formatIndex_o !== 3'd2) begin
            errors++; $display("FAIL bp_head_a: valid=%b imm=%h idx=%0d want 1/a1/2", bus.valid_o, bus.imm_o, bus.formatIndex_o);
        end
        bus.ready_i = 1'b1;
        tick();
        checks++; if (bus.ready_o !== 1'b1 || bus.imm_o !== 64'hB2 || bus.formatIndex_o !== 3'd5) begin
            errors++; $display("FAIL bp_head_b: ready=%b imm=%h idx=%0d want 1/b2/5", bus.ready_o, bus.imm_o, bus.formatIndex_o);
        end
        tick();
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL bp_third_dropped: valid=%b want 0", bus.valid_o); end
    endtask

    task automatic test_zero_extend();
        clear_inputs();
        bus.ready_i = 1'b0;
        set_ch(4, 16'h8000, 6'd4, 1'b0, 40'h5);
        tick();
        clear_inputs();
        checks++; if (bus.imm_o !== 64'h0000_0000_0008_0000) begin errors++; $display("FAIL zext_imm: got %h want 80000", bus.imm_o); end
        bus.ready_i = 1'b1;
        tick();
        bus.ready_i = 1'b0;
        set_ch(0, 16'hFFFF, 6'd63, 1'b1, 40'h6);
        tick();
        clear_inputs();
        checks++; if (bus.imm_o !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL shift63_imm: got %h want 8000000000000000", bus.imm_o); end
        bus.ready_i = 1'b1;
        tick();
    endtask

    task automatic test_flush();
        clear_inputs();
        bus.ready_i = 1'b0;
        set_ch(1, 16'h1, 6'd0, 1'b0, 40'h1);
        tick();
        tick();
        checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL flush_prefull: ready=%b want 0", bus.ready_o); end
        bus.flush_i = 1'b1;
        bus.ready_i = 1'b1;
        tick();
        clear_inputs();
        checks++; if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
            errors++; $display("FAIL flush_state: valid=%b ready=%b want 0/1", bus.valid_o, bus.ready_o);
        end
        tick();
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL flush_hit_dropped: valid=%b want 0", bus.valid_o); end
    endtask

    task automatic test_reset_midstream();
        clear_inputs();
        bus.ready_i = 1'b0;
        set_ch(2, 16'hFFF0, 6'd2, 1'b1, 40'h77);
        tick();
        clear_inputs();
        checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL midrst_pre: valid=%b want 1", bus.valid_o); end
        rst = 1'b1;
        bus.flush_i = 1'b1;
        tick();
        rst = 1'b0;
        bus.flush_i = 1'b0;
        checks++; if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1 || bus.imm_o !== 64'd0) begin
            errors++; $display("FAIL midrst_state: valid=%b ready=%b imm=%h want 0/1/0", bus.valid_o, bus.ready_o, bus.imm_o);
        end
`ifdef DECODE_MUX_PERF_EN
        checks++; if (bus.perfIssued_o !== 32'd0 || bus.perfCollide_o !== 32'd0 || bus.perfStall_o !== 32'd0) begin
            errors++; $display("FAIL midrst_perf: issued=%0d collide=%0d stall=%0d want 0", bus.perfIssued_o, bus.perfCollide_o, bus.perfStall_o);
        end
`endif
    endtask

    task automatic test_random();
        entry_t e;
        logic [63:0] r64;
        logic [NUM_FMT-1:0] v;
        bit do_pop;
        bit do_push;
        int cnt_issued;
        int cnt_collide;
        int cnt_stall;
        cnt_issued  = 0;
        cnt_collide = 0;
        cnt_stall   = 0;
        clear_inputs();
        bus.ready_i = 1'b0;
        do_reset();
        model_q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            checks++;
            if (bus.valid_o !== (model_q.size() != 0) || bus.ready_o !== (model_q.size() != DEPTH)) begin
                errors++;
                $display("FAIL rnd_flags cyc %0d: valid=%b ready=%b model_size=%0d", cyc, bus.valid_o, bus.ready_o, model_q.size());
            end
            if (model_q.size() != 0) begin
                checks++;
                if (bus.instructionAddress_o !== model_q[0].addr || bus.opcode_o !== model_q[0].opc ||
                    bus.imm_o !== model_q[0].imm || bus.ctrl_o !== model_q[0].ctrl ||
                    bus.formatIndex_o !== model_q[0].idx || bus.multiHit_o !== model_q[0].multi) begin
                    errors++;
                    $display("FAIL rnd_head cyc %0d: imm=%h idx=%0d multi=%b ctrl=%h want imm=%h idx=%0d multi=%b ctrl=%h",
                             cyc, bus.imm_o, bus.formatIndex_o, bus.multiHit_o, bus.ctrl_o,
                             model_q[0].imm, model_q[0].idx, model_q[0].multi, model_q[0].ctrl);
                end
            end
`ifdef DECODE_MUX_PERF_EN
            checks++;
            if (bus.perfIssued_o !== 32'(cnt_issued) || bus.perfCollide_o !== 32'(cnt_collide) || bus.perfStall_o !== 32'(cnt_stall)) begin
                errors++;
                $display("FAIL rnd_perf cyc %0d: %0d/%0d/%0d want %0d/%0d/%0d", cyc, bus.perfIssued_o,
                         bus.perfCollide_o, bus.perfStall_o, cnt_issued, cnt_collide, cnt_stall);
            end
`endif
            clear_inputs();
            v = ($urandom_range(0, 3) == 0) ? '0 : NUM_FMT'($urandom_range(1, 63));
            for (int k = 0; k < NUM_FMT; k++) begin
                if (v[k]) begin
                    r64 = {$urandom, $urandom};
                    set_ch(k, r64[15:0], r64[21:16], r64[22], r64[63:24]);
                end
            end
            r64 = {$urandom, $urandom};
            bus.instructionAddress_i = r64;
            bus.opcode_i             = r64[37:32];
            bus.ready_i              = ($urandom_range(0, 2) != 0);
            bus.flush_i              = ($urandom_range(0, 24) == 0);

            if (v != 0 && model_q.size() == DEPTH) cnt_stall++;
            do_pop  = (model_q.size() != 0) && bus.ready_i && !bus.flush_i;
            do_push = (v != 0) && (model_q.size() != DEPTH) && !bus.flush_i;
            if (do_pop) cnt_issued++;
            if (do_push && $countones(v) > 1) cnt_collide++;
            if (bus.flush_i) model_q.delete();
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                for (int k = 0; k < NUM_FMT; k++) begin
                    if (v[k]) begin
                        e.addr  = bus.instructionAddress_i;
                        e.opc   = bus.opcode_i;
                        e.imm   = ref_imm(bus.fmtImm_i[k*IMM_W +: IMM_W], bus.fmtImmSigned_i[k], bus.fmtImmShift_i[k*6 +: 6]);
                        e.ctrl  = bus.fmtCtrl_i[k*CTRL_W +: CTRL_W];
                        e.idx   = IDX_W'(k);
                        e.multi = ($countones(v) > 1);
                        model_q.push_back(e);
                        break;
                    end
                end
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        bus.ready_i = 1'b0;
        clear_inputs();
        test_reset();
        test_single_hit();
        test_collision();
        test_backpressure();
        test_zero_extend();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
